// File: rtl/uart_rx_ctrl.sv
// UART receive controller: 16x-oversampled start detection, LSB-first data shift,
// optional parity and stop-bit check, one validated byte (or one error pulse) per frame.
module uart_rx_ctrl #(
   parameter int DATA_W     = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              RX_tick,
   input  logic              RX_IN,
   input  logic              PAR_EN,
   input  logic              PAR_TYP,
   output logic [DATA_W-1:0] P_DATA,
   output logic              DATA_VALID,
   output logic              PAR_ERR,
   output logic              STP_ERR,
   output logic              BUSY
);

   localparam int PH_W = $clog2(OVERSAMPLE);
   localparam int BC_W = $clog2(DATA_W + 1);
   localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVERSAMPLE / 2 - 1);
   localparam logic [PH_W-1:0] PH_END  = PH_W'(OVERSAMPLE - 1);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              sync1;
   logic              rx_s;
   logic              armed;
   logic              par_en_l;
   logic              par_typ_l;
   logic              perr;
   logic [PH_W-1:0]   phase;
   logic [BC_W-1:0]   bit_cnt;
   logic [DATA_W-1:0] shreg;

   logic              sample_pt;
   logic              bit_end;
   logic              start_det;
   logic              arm_set;
   logic              data_start;
   logic              shift_en;
   logic              par_smp;
   logic              frame_end;

   // Two-flop synchronizer, preset to the idle level so reset never looks like a start bit.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         sync1 <= RX_IN;
         rx_s  <= sync1;
      end
   end

   assign sample_pt = RX_tick && (phase == PH_MID);
   assign bit_end   = RX_tick && (phase == PH_END);
   assign BUSY      = (state != S_IDLE);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= S_IDLE;
      end else if (RX_tick) begin
         state <= state_nxt;
      end
   end

   // A start edge only counts once the line has been seen high in IDLE (armed), so a held-low
   // break cannot retrigger. STOP leaves at its midpoint to catch an immediately following frame.
   always_comb begin
      state_nxt  = state;
      start_det  = 1'b0;
      arm_set    = 1'b0;
      data_start = 1'b0;
      shift_en   = 1'b0;
      par_smp    = 1'b0;
      frame_end  = 1'b0;
      case (state)
         S_IDLE: begin
            if (RX_tick) begin
               if (rx_s) begin
                  arm_set = 1'b1;
               end else if (armed) begin
                  start_det = 1'b1;
                  state_nxt = S_START;
               end
            end
         end
         S_START: begin
            if (sample_pt && rx_s) begin
               state_nxt = S_IDLE;
            end else if (bit_end) begin
               data_start = 1'b1;
               state_nxt  = S_DATA;
            end
         end
         S_DATA: begin
            shift_en = sample_pt;
            if (bit_end && (bit_cnt == BC_LAST)) begin
               state_nxt = par_en_l ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            par_smp = sample_pt;
            if (bit_end) begin
               state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            if (sample_pt) begin
               frame_end = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath; result pulses last a single CLK regardless of tick spacing.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         phase      <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         armed      <= 1'b0;
         par_en_l   <= 1'b0;
         par_typ_l  <= 1'b0;
         perr       <= 1'b0;
         P_DATA     <= '0;
         DATA_VALID <= 1'b0;
         PAR_ERR    <= 1'b0;
         STP_ERR    <= 1'b0;
      end else begin
         DATA_VALID <= 1'b0;
         PAR_ERR    <= 1'b0;
         STP_ERR    <= 1'b0;
         if (RX_tick) begin
            if (start_det || (phase == PH_END)) begin
               phase <= '0;
            end else begin
               phase <= phase + 1'b1;
            end
         end
         if (arm_set) begin
            armed <= 1'b1;
         end else if (start_det) begin
            armed <= 1'b0;
         end
         if (start_det) begin
            par_en_l  <= PAR_EN;
            par_typ_l <= PAR_TYP;
            perr      <= 1'b0;
         end
         if (data_start) begin
            bit_cnt <= '0;
         end
         if (shift_en) begin
            shreg   <= {rx_s, shreg[DATA_W-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
         end
         if (par_smp) begin
            perr <= rx_s ^ (^shreg) ^ par_typ_l;
         end
         if (frame_end) begin
            if (!rx_s) begin
               STP_ERR <= 1'b1;
            end else if (perr) begin
               PAR_ERR <= 1'b1;
            end else begin
               P_DATA     <= shreg;
               DATA_VALID <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed frames plus randomized frames, with a
// frame-level expected-event queue compared against the DUT pulses on every cycle.
module tb_uart_rx_ctrl;

   localparam int DW = 8;
   localparam int OS = 16;

   logic          CLK     = 1'b0;
   logic          RST     = 1'b0;
   logic          RX_tick = 1'b0;
   logic          RX_IN   = 1'b1;
   logic          PAR_EN  = 1'b0;
   logic          PAR_TYP = 1'b0;
   logic [DW-1:0] P_DATA;
   logic          DATA_VALID;
   logic          PAR_ERR;
   logic          STP_ERR;
   logic          BUSY;

   int total   = 0;
   int bad     = 0;
   int tickGap = 4;
   int tickCnt = 0;
   bit checkEn = 1'b0;

   typedef enum int {EV_VALID, EV_PERR, EV_SERR} evKind_t;
   typedef struct {
      evKind_t       kind;
      logic [DW-1:0] data;
   } ev_t;

   ev_t           expQ[$];
   logic [DW-1:0] modelPData = '0;
   int            cmpPulses;
   ev_t           cmpEv;

   uart_rx_ctrl #(.DATA_W(DW), .OVERSAMPLE(OS)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .RX_tick   (RX_tick),
      .RX_IN     (RX_IN),
      .PAR_EN    (PAR_EN),
      .PAR_TYP   (PAR_TYP),
      .P_DATA    (P_DATA),
      .DATA_VALID(DATA_VALID),
      .PAR_ERR   (PAR_ERR),
      .STP_ERR   (STP_ERR),
      .BUSY      (BUSY)
   );

   always #5 CLK = ~CLK;

   // Oversample strobe: one CLK high every tickGap CLKs.
   initial begin
      forever begin
         @(posedge CLK);
         #1;
         if (tickCnt >= tickGap - 1) begin
            RX_tick = 1'b1;
            tickCnt = 0;
         end else begin
            RX_tick = 1'b0;
            tickCnt++;
         end
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, bad=%0d", bad);
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] kindBits(input evKind_t k);
      case (k)
         EV_VALID: return 3'b100;
         EV_PERR:  return 3'b010;
         default:  return 3'b001;
      endcase
   endfunction

   task automatic waitTicks(input int n);
      for (int i = 0; i < n; i++) begin
         do @(posedge CLK); while (RX_tick !== 1'b1);
      end
      #2;
   endtask

   // Drives one frame tick-accurately and queues the single outcome the frame must produce.
   task automatic applyStimulus(input logic [DW-1:0] data, input bit parEn, input bit parTyp,
                                input bit parFlip, input bit stopBit, input int gap,
                                input bit scramble);
      ev_t e;
      PAR_EN  = parEn;
      PAR_TYP = parTyp;
      e.data  = data;
      if (!stopBit)
         e.kind = EV_SERR;
      else if (parEn && parFlip)
         e.kind = EV_PERR;
      else
         e.kind = EV_VALID;
      expQ.push_back(e);
      RX_IN = 1'b0;
      waitTicks(OS);
      if (scramble) begin
         PAR_EN  = 1'($urandom);
         PAR_TYP = 1'($urandom);
      end
      for (int i = 0; i < DW; i++) begin
         RX_IN = data[i];
         waitTicks(OS);
      end
      if (parEn) begin
         RX_IN = (^data) ^ parTyp ^ parFlip;
         waitTicks(OS);
      end
      RX_IN = stopBit;
      checkOutput("no_early_event", expQ.size(), 1);
      waitTicks(OS);
      checkOutput("event_in_stop_bit", expQ.size(), 0);
      RX_IN = 1'b1;
      if (gap > 0) waitTicks(gap);
   endtask

   // Every cycle: at most one pulse, each pulse matches the next queued outcome, P_DATA holds.
   always @(negedge CLK) begin
      if (RST && checkEn) begin
         cmpPulses = int'(DATA_VALID) + int'(PAR_ERR) + int'(STP_ERR);
         checkOutput("pulse_count_le1", 32'(cmpPulses > 1), 0);
         if (cmpPulses != 0) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_pulse", {DATA_VALID, PAR_ERR, STP_ERR}, 0);
            end else begin
               cmpEv = expQ.pop_front();
               checkOutput("pulse_kind", {DATA_VALID, PAR_ERR, STP_ERR}, kindBits(cmpEv.kind));
               if (cmpEv.kind == EV_VALID) modelPData = cmpEv.data;
            end
         end
         checkOutput("p_data_model", P_DATA, modelPData);
      end
   end

   initial begin
      logic [DW-1:0] rData;
      bit rParEn, rParTyp, rFlip, rStop;
      int rGap;

      RST   = 1'b0;
      RX_IN = 1'b1;
      repeat (3) @(posedge CLK);
      #2;
      checkOutput("reset_p_data", P_DATA, 0);
      checkOutput("reset_flags", {DATA_VALID, PAR_ERR, STP_ERR}, 0);
      checkOutput("reset_busy", BUSY, 0);
      RST     = 1'b1;
      checkEn = 1'b1;
      waitTicks(4);

      applyStimulus(8'hA5, 0, 0, 0, 1, 4, 0);
      checkOutput("lit_a5", P_DATA, 8'hA5);
      applyStimulus(8'h3C, 1, 0, 0, 1, 4, 0);
      checkOutput("lit_3c_even_ok", P_DATA, 8'h3C);
      applyStimulus(8'h3C, 1, 0, 1, 1, 4, 0);
      checkOutput("lit_3c_after_perr", P_DATA, 8'h3C);
      applyStimulus(8'h81, 1, 1, 1, 0, 8, 0);
      checkOutput("lit_after_stp_err", P_DATA, 8'h3C);

      RX_IN = 1'b0;
      waitTicks(4);
      checkOutput("glitch_busy_rise", BUSY, 1);
      RX_IN = 1'b1;
      waitTicks(8);
      checkOutput("glitch_busy_fall", BUSY, 0);
      waitTicks(4);

      applyStimulus(8'h55, 0, 0, 0, 1, 0, 0);
      checkOutput("lit_b2b_first", P_DATA, 8'h55);
      applyStimulus(8'hAA, 0, 0, 0, 1, 4, 0);
      checkOutput("lit_b2b_second", P_DATA, 8'hAA);

      // Line held low for three frame times: one stop error, then no restart.
      PAR_EN = 1'b0;
      begin
         ev_t e;
         e.kind = EV_SERR;
         e.data = '0;
         expQ.push_back(e);
      end
      RX_IN = 1'b0;
      waitTicks(3 * 10 * OS);
      checkOutput("break_single_stp", expQ.size(), 0);
      checkOutput("break_no_restart", BUSY, 0);
      RX_IN = 1'b1;
      waitTicks(8);
      applyStimulus(8'h5A, 0, 0, 0, 1, 4, 0);
      checkOutput("lit_after_break", P_DATA, 8'h5A);

      // Reset in the middle of the data bits of 0xF0.
      RX_IN = 1'b0;
      waitTicks(OS);
      for (int i = 0; i < 3; i++) begin
         RX_IN = 1'b0;
         waitTicks(OS);
      end
      waitTicks(5);
      checkOutput("busy_mid_frame", BUSY, 1);
      RST = 1'b0;
      #1;
      checkOutput("midreset_p_data", P_DATA, 0);
      checkOutput("midreset_busy", BUSY, 0);
      checkOutput("midreset_flags", {DATA_VALID, PAR_ERR, STP_ERR}, 0);
      expQ.delete();
      modelPData = '0;
      RX_IN = 1'b1;
      repeat (3) @(posedge CLK);
      #3;
      RST = 1'b1;
      waitTicks(4);
      applyStimulus(8'h12, 0, 0, 0, 1, 4, 0);
      checkOutput("lit_after_reset", P_DATA, 8'h12);

      // Randomized frames, tick spacing, parity settings and errors.
      for (int n = 0; n < 40; n++) begin
         tickGap = int'($urandom_range(1, 4));
         rData   = DW'($urandom);
         rParEn  = 1'($urandom);
         rParTyp = 1'($urandom);
         rFlip   = ($urandom_range(0, 3) == 0);
         rStop   = ($urandom_range(0, 4) != 0);
         rGap    = rStop ? int'($urandom_range(0, 6)) : int'($urandom_range(6, 12));
         applyStimulus(rData, rParEn, rParTyp, rFlip, rStop, rGap, 1);
      end

      waitTicks(2 * OS);
      checkOutput("queue_drained", expQ.size(), 0);
      checkOutput("idle_at_end", BUSY, 0);
      checkEn = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
